// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO one byte at a time and sends each byte as an 8N1 frame
// (start bit, 8 data bits LSB first, stop bit) with busy/done status and a frame counter.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);

  state_t           state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic [15:0]      baud_q;
  logic             fifo_rd_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic             bit_end;
  logic [15:0]      baud_d;
  logic [CNT_W-1:0] frame_cnt_d;

  assign bit_end     = (baud_q == BAUD_LAST);
  assign baud_d      = bit_end ? 16'd0 : baud_q + 16'd1;
  assign frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= 8'd0;
      bit_idx_q   <= 3'd0;
      baud_q      <= 16'd0;
      fifo_rd_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      fifo_rd_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          // The pop happens only after seeing a non-empty FIFO; we are its sole reader.
          if (en && !fifo_empty) begin
            state_q   <= FETCH;
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          shift_q <= fifo_data;
          baud_q  <= 16'd0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          baud_q <= baud_d;
          if (bit_end) begin
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          baud_q <= baud_d;
          if (bit_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
        STOP: begin
          baud_q <= baud_d;
          // Raise done one edge early so the registered pulse lands on the last stop cycle.
          if (baud_q == BAUD_PRE) begin
            done_q      <= 1'b1;
            frame_cnt_q <= frame_cnt_d;
          end
          if (bit_end) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule
